// File: rtl/output_port_allocator.sv
// Output-port switch allocator: round-robin, wormhole lock, credits.
// Optional stall counter enabled by OUTPUT_ALLOC_STALL_CNT_EN.
module output_port_allocator #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH+1),
  parameter int IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   turn_disable,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic                    send_out,
  output logic                    is_tail_out,
  output logic                    locked,
  output logic [IDX_WIDTH-1:0]    owner,
  output logic [CREDIT_WIDTH-1:0] credit_count,
`ifdef OUTPUT_ALLOC_STALL_CNT_EN
  output logic [31:0]             stall_cycles,
`endif
  output logic                    credit_overflow
);

  localparam logic [CREDIT_WIDTH-1:0] FULL =
    CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  logic                    r_locked;
  logic [IDX_WIDTH-1:0]    r_owner;
  logic [IDX_WIDTH-1:0]    r_rr_ptr;
  logic [CREDIT_WIDTH-1:0] r_credit;
  logic                    r_ovf;

  logic [NUM_INPUTS-1:0]   w_elig;
  logic [NUM_INPUTS-1:0]   w_own_mask;
  logic [NUM_INPUTS-1:0]   w_grant;
  logic [IDX_WIDTH-1:0]    w_hi;
  logic [IDX_WIDTH-1:0]    w_lo;
  logic [IDX_WIDTH-1:0]    w_win;
  logic                    w_hi_vld;
  logic                    w_can_send;
  logic                    w_send;
  logic                    w_tail;

  function automatic logic [IDX_WIDTH-1:0] f_next(
    input logic [IDX_WIDTH-1:0] x
  );
    if (x == IDX_WIDTH'(NUM_INPUTS-1))
      f_next = '0;
    else
      f_next = x + IDX_WIDTH'(1);
  endfunction

  assign w_elig     = req & ~turn_disable;
  assign w_can_send = (r_credit != '0);

  // Lowest eligible index at/above rr_ptr, else lowest overall (wrap).
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    w_hi_vld = 1'b0;
    for (int i = NUM_INPUTS-1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo = IDX_WIDTH'(i);
        if (IDX_WIDTH'(i) >= r_rr_ptr) begin
          w_hi     = IDX_WIDTH'(i);
          w_hi_vld = 1'b1;
        end
      end
    end
    w_win = w_hi_vld ? w_hi : w_lo;
  end

  always_comb begin
    w_own_mask = '0;
    w_grant    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_own_mask[i] = (r_owner == IDX_WIDTH'(i));
      if (r_locked)
        w_grant[i] = w_own_mask[i] & req[i] & w_can_send;
      else
        w_grant[i] = w_can_send & (|w_elig)
                   & (w_win == IDX_WIDTH'(i));
    end
  end

  assign w_send = |w_grant;
  assign w_tail = |(w_grant & req_is_tail);

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      r_locked <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_credit <= FULL;
      r_ovf    <= 1'b0;
    end else begin
      if (r_locked) begin
        if (w_send && w_tail) begin
          r_locked <= 1'b0;
          r_rr_ptr <= f_next(r_owner);
        end
      end else if (w_send) begin
        if (w_tail) begin
          r_rr_ptr <= f_next(w_win);
        end else begin
          r_locked <= 1'b1;
          r_owner  <= w_win;
        end
      end
      if (w_send && !credit_in) begin
        r_credit <= r_credit - CREDIT_WIDTH'(1);
      end else if (credit_in && !w_send) begin
        if (r_credit == FULL)
          r_ovf <= 1'b1;
        else
          r_credit <= r_credit + CREDIT_WIDTH'(1);
      end
    end
  end

`ifdef OUTPUT_ALLOC_STALL_CNT_EN
  logic [31:0] r_stall;
  logic        w_pending;

  assign w_pending = r_locked ? |(req & w_own_mask) : |w_elig;

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc)
      r_stall <= '0;
    else if (w_pending && !w_can_send && r_stall != '1)
      r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles = r_stall;
`endif

  assign grant           = w_grant;
  assign send_out        = w_send;
  assign is_tail_out     = w_tail;
  assign locked          = r_locked;
  assign owner           = r_owner;
  assign credit_count    = r_credit;
  assign credit_overflow = r_ovf;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator with a cycle model.
// Define OUTPUT_ALLOC_STALL_CNT_EN to cover the stall counter.
module tb_output_port_allocator;

  localparam int N     = 5;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] tail = '0;
  logic [N-1:0] tdis = '0;
  logic         cin = 1'b0;
  logic [N-1:0] grant;
  logic         send_out;
  logic         is_tail_out;
  logic         locked;
  logic [2:0]   owner;
  logic [3:0]   credit_count;
  logic         credit_overflow;
`ifdef OUTPUT_ALLOC_STALL_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  output_port_allocator dut (
    .clk_noc         (clk),
    .rst_noc         (rst),
    .req             (req),
    .req_is_tail     (tail),
    .turn_disable    (tdis),
    .credit_in       (cin),
    .grant           (grant),
    .send_out        (send_out),
    .is_tail_out     (is_tail_out),
    .locked          (locked),
    .owner           (owner),
    .credit_count    (credit_count),
`ifdef OUTPUT_ALLOC_STALL_CNT_EN
    .stall_cycles    (stall_cycles),
`endif
    .credit_overflow (credit_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: state after the most recent edge.
  bit           m_locked = 0;
  int           m_owner = 0;
  int           m_rr = 0;
  int           m_cred = DEPTH;
  bit           m_ovf = 0;
  logic [31:0]  m_stall = '0;
  logic [N-1:0] elig;
  logic [N-1:0] e_grant;
  logic         e_tail;
  logic         pend;
  int           w;
  int           idx;

  always @(negedge clk) begin
    if (rst) begin
      m_locked = 0;
      m_owner  = 0;
      m_rr     = 0;
      m_cred   = DEPTH;
      m_ovf    = 0;
      m_stall  = '0;
    end else begin
      elig    = req & ~tdis;
      e_grant = '0;
      w       = -1;
      if (m_cred != 0) begin
        if (m_locked) begin
          if (req[m_owner]) w = m_owner;
        end else begin
          for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (w < 0 && elig[idx]) w = idx;
          end
        end
      end
      if (w >= 0) e_grant[w] = 1'b1;
      e_tail = (w >= 0) ? tail[w] : 1'b0;
      chk("grant", grant, e_grant);
      chk("send_out", send_out, w >= 0);
      chk("is_tail_out", is_tail_out, e_tail);
      chk("onehot", $countones(grant) <= 1, 1);
      chk("locked", locked, m_locked);
      if (m_locked) chk("owner", owner, m_owner);
      chk("credit_count", credit_count, m_cred);
      chk("credit_overflow", credit_overflow, m_ovf);
`ifdef OUTPUT_ALLOC_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
      pend = m_locked ? req[m_owner] : |elig;
      if (pend && m_cred == 0 && m_stall != '1)
        m_stall = m_stall + 1;
`endif
      if (w >= 0 && !cin) begin
        m_cred--;
      end else if (cin && w < 0) begin
        if (m_cred == DEPTH) m_ovf = 1;
        else m_cred++;
      end
      if (w >= 0) begin
        if (m_locked) begin
          if (e_tail) begin
            m_locked = 0;
            m_rr = (w + 1) % N;
          end
        end else if (e_tail) begin
          m_rr = (w + 1) % N;
        end else begin
          m_locked = 1;
          m_owner = w;
        end
      end
    end
  end

  task automatic cyc(input logic [N-1:0] r,
                     input logic [N-1:0] t,
                     input logic [N-1:0] d,
                     input logic c,
                     input logic [N-1:0] eg);
    req = r; tail = t; tdis = d; cin = c;
    #1;
    chk("lit_grant", grant, eg);
    chk("lit_send", send_out, |eg);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_credit", credit_count, 8);
    chk("rst_locked", locked, 0);
    chk("rst_ovf", credit_overflow, 0);

    // Single-flit packets alternate between inputs 1 and 2
    cyc(5'b00110, 5'b11111, 0, 0, 5'b00010);
    cyc(5'b00110, 5'b11111, 0, 0, 5'b00100);
    cyc(5'b00110, 5'b11111, 0, 0, 5'b00010);
    cyc(5'b00110, 5'b11111, 0, 0, 5'b00100);
    chk("rr_credit", credit_count, 4);
    repeat (4) cyc(0, 0, 0, 1, 0);
    chk("refill", credit_count, 8);

    // Three-flit packet on input 3 locks out input 1
    cyc(5'b01010, 5'b00010, 0, 0, 5'b01000);
    chk("pk_locked", locked, 1);
    chk("pk_owner", owner, 3);
    cyc(5'b01010, 5'b00010, 0, 0, 5'b01000);
    chk("pk_owner2", owner, 3);
    cyc(5'b01010, 5'b01010, 0, 0, 5'b01000);
    chk("pk_unlock", locked, 0);
    cyc(5'b00010, 5'b00010, 0, 0, 5'b00010);

    // Drain credits, then a single returned credit
    repeat (4) cyc(5'b00100, 5'b00100, 0, 0, 5'b00100);
    chk("drained", credit_count, 0);
    cyc(5'b00100, 5'b00100, 0, 0, 0);
    cyc(5'b00100, 5'b00100, 0, 1, 0);
    cyc(5'b00100, 5'b00100, 0, 0, 5'b00100);
    cyc(5'b00100, 5'b00100, 0, 0, 0);
    chk("back_to_0", credit_count, 0);

    // Simultaneous grant and credit, then overflow
    repeat (5) cyc(0, 0, 0, 1, 0);
    chk("at5", credit_count, 5);
    cyc(5'b00100, 5'b00100, 0, 1, 5'b00100);
    chk("same_cycle", credit_count, 5);
    repeat (3) cyc(0, 0, 0, 1, 0);
    chk("full", credit_count, 8);
    chk("no_ovf", credit_overflow, 0);
    cyc(0, 0, 0, 1, 0);
    chk("sat", credit_count, 8);
    chk("ovf", credit_overflow, 1);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_sticky", credit_overflow, 1);

    // turn_disable masks idle requests but not a held lock
    cyc(5'b00001, 5'b00001, 5'b00001, 0, 0);
    cyc(5'b00001, 0, 0, 0, 5'b00001);
    chk("td_lock", locked, 1);
    chk("td_owner", owner, 0);
    cyc(5'b00001, 0, 5'b00001, 0, 5'b00001);
    cyc(5'b00001, 5'b00001, 5'b00001, 0, 5'b00001);
    chk("td_unlock", locked, 0);
    cyc(5'b00001, 5'b00001, 5'b00001, 0, 0);
    chk("td_credit", credit_count, 5);

    // Asynchronous reset mid-packet
    repeat (3) cyc(5'b10000, 0, 0, 0, 5'b10000);
    chk("pre_rst_credit", credit_count, 2);
    chk("pre_rst_lock", locked, 1);
    rst = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_credit", credit_count, 8);
`ifdef OUTPUT_ALLOC_STALL_CNT_EN
    chk("arst_stall", stall_cycles, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(5'b00001, 5'b00001, 0, 0, 5'b00001);
    cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
